// File: rtl/snake_pkg.sv
// snake_pkg
// Shared definitions for the snake game-flow controller: game state
// encoding, score width and the score saturation helper.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int                 SCORE_W   = 8;
    localparam logic [SCORE_W-1:0] SCORE_SAT = 8'd255;

    // Score increment that sticks at SCORE_SAT instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_SAT) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Two-flop synchroniser, level debouncer and rising-edge pulse for one
// raw push button. Reusable for any KEY input.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   key    in   raw asynchronous button level, active-high
//   press  out  one-cycle pulse when the debounced level goes 0 -> 1
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             kst;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronised samples that disagree with kst;
    // the sample that makes DEBOUNCE_CYCLES flips kst. Releases only flip
    // kst, they never produce a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            kst    <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == kst) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                kst   <= sync_b;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_sequencer.sv
// snake_sequencer
// Game-flow controller for the snake datapath: debounced turn/start button,
// periodic move strobe, IDLE/RUN/OVER sequencing, score and speed-up.
//
// Ports:
//   clk        in   slow game clock
//   rst        in   synchronous active-high reset
//   key        in   raw button, active-high, asynchronous
//   collision  in   head-collision level, valid in the cycle after step
//   eaten      in   one-cycle pulse, food consumed
//   step       out  one-cycle move strobe
//   turn       out  one-cycle turn command, only together with step
//   clear      out  one-cycle pulse, datapath reloads the initial snake
//   running    out  high in RUN
//   game_over  out  high in OVER
//   score      out  food count, saturating at 255
//   period     out  current move period in clk cycles
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a press to start; score of last game visible
// RUN   | tick counter generates step; presses queue turns
// OVER  | frozen; press accepted once hold counter reaches OVER_HOLD
module snake_sequencer
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_INIT       = 1000,
    parameter int TICK_MIN        = 200,
    parameter int TICK_STEP       = 50,
    parameter int OVER_HOLD       = 500,
    parameter int PER_W           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key,
    input  logic               collision,
    input  logic               eaten,
    output logic               step,
    output logic               turn,
    output logic               clear,
    output logic               running,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [PER_W-1:0]   period
);

    localparam logic [PER_W-1:0] PER_INIT = PER_W'(TICK_INIT);
    localparam logic [PER_W-1:0] PER_MIN  = PER_W'(TICK_MIN);
    localparam logic [PER_W-1:0] PER_STEP = PER_W'(TICK_STEP);
    localparam logic [PER_W-1:0] HOLD_MAX = PER_W'(OVER_HOLD);
    // Smallest period that can take a full TICK_STEP without going below
    // the floor; one extra bit so the sum cannot overflow.
    localparam logic [PER_W:0]   DEC_LIMIT = (PER_W + 1)'(TICK_MIN + TICK_STEP);

    game_state_t      state;
    logic             press;
    logic [PER_W-1:0] tick_cnt;
    logic [PER_W-1:0] hold_cnt;
    logic             turn_pending;
    logic             step_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .press(press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            turn_pending <= 1'b0;
            step_d       <= 1'b0;
            step         <= 1'b0;
            turn         <= 1'b0;
            clear        <= 1'b0;
            running      <= 1'b0;
            game_over    <= 1'b0;
            score        <= '0;
            period       <= PER_INIT;
        end else begin
            step   <= 1'b0;
            turn   <= 1'b0;
            clear  <= 1'b0;
            // step_d marks the one cycle in which collision is meaningful.
            step_d <= step;

            case (state)
                IDLE: begin
                    if (press) begin
                        state        <= RUN;
                        clear        <= 1'b1;
                        running      <= 1'b1;
                        score        <= '0;
                        period       <= PER_INIT;
                        tick_cnt     <= '0;
                        turn_pending <= 1'b0;
                    end
                end

                RUN: begin
                    // >= rather than == so a period that just shrank below
                    // the running count fires on the following cycle.
                    if (tick_cnt >= period - 1'b1) begin
                        tick_cnt     <= '0;
                        step         <= 1'b1;
                        turn         <= turn_pending;
                        turn_pending <= press;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (press) begin
                            turn_pending <= 1'b1;
                        end
                    end

                    if (eaten) begin
                        score  <= score_inc(score);
                        period <= ({1'b0, period} >= DEC_LIMIT) ? period - PER_STEP : PER_MIN;
                    end

                    if (step_d && collision) begin
                        state     <= OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                        hold_cnt  <= '0;
                        step      <= 1'b0;
                        turn      <= 1'b0;
                    end
                end

                OVER: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (press) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_sequencer.sv
module tb_snake_sequencer;

    localparam int DEB    = 4;
    localparam int T_INIT = 20;
    localparam int T_MIN  = 8;
    localparam int T_STEP = 5;
    localparam int HOLD   = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic        collision;
    logic        eaten;
    logic        step;
    logic        turn;
    logic        clear;
    logic        running;
    logic        game_over;
    logic [7:0]  score;
    logic [15:0] period;

    int cyc        = 0;
    int clear_cnt  = 0;
    int step_cnt   = 0;
    int checks     = 0;
    int passed     = 0;
    int eaten_total = 0;

    snake_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_INIT      (T_INIT),
        .TICK_MIN       (T_MIN),
        .TICK_STEP      (T_STEP),
        .OVER_HOLD      (HOLD),
        .PER_W          (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .collision(collision),
        .eaten    (eaten),
        .step     (step),
        .turn     (turn),
        .clear    (clear),
        .running  (running),
        .game_over(game_over),
        .score    (score),
        .period   (period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clear === 1'b1) clear_cnt <= clear_cnt + 1;
        if (step === 1'b1) step_cnt <= step_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Reference rules: score saturates at 255; each food shortens the period
    // by T_STEP down to a floor of T_MIN.
    function automatic int exp_score(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int exp_period(input int n);
        int p;
        p = T_INIT - n * T_STEP;
        return (p < T_MIN) ? T_MIN : p;
    endfunction

    // which: 0 = step high, 1 = clear high, 2 = game_over low.
    // n = negedges waited until seen, -1 if the budget expired.
    task automatic wait_sig(input int which, input int limit, output int n);
        logic hit;
        n = -1;
        hit = 1'b0;
        for (int i = 1; i <= limit && !hit; i++) begin
            @(negedge clk);
            if ((which == 0 && step === 1'b1) || (which == 1 && clear === 1'b1) ||
                (which == 2 && game_over === 1'b0)) begin
                n = i;
                hit = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 1'b0; collision = 1'b0; eaten = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (step !== 1'b0) $display("FAIL reset_step: got %b expected 0", step); else passed++;
        checks++; if (turn !== 1'b0) $display("FAIL reset_turn: got %b expected 0", turn); else passed++;
        checks++; if (clear !== 1'b0) $display("FAIL reset_clear: got %b expected 0", clear); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else passed++;
        checks++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %b expected 0", game_over); else passed++;
        checks++; if (score !== 8'd0) $display("FAIL reset_score: got %0d expected 0", score); else passed++;
        checks++; if (int'(period) !== T_INIT) $display("FAIL reset_period: got %0d expected %0d", period, T_INIT); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bouncy_start();
        int c0, n;
        c0 = clear_cnt;
        for (int i = 0; i < 6; i++) begin
            key = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        key = 1'b1;
        wait_sig(1, 20, n);
        checks++; if (n < 6 || n > 8) $display("FAIL bounce_latency: got %0d expected 6..8", n); else passed++;
        checks++; if (running !== 1'b1) $display("FAIL start_running: got %b expected 1", running); else passed++;
        key = 1'b0;
        wait_sig(0, 40, n);
        checks++; if (n !== T_INIT) $display("FAIL first_step_delay: got %0d expected %0d", n, T_INIT); else passed++;
        checks++; if (turn !== 1'b0) $display("FAIL first_step_turn: got %b expected 0", turn); else passed++;
        checks++; if (clear_cnt - c0 !== 1) $display("FAIL bounce_one_press: got %0d expected 1", clear_cnt - c0); else passed++;
    endtask

    task automatic test_turns();
        int n, k;
        wait_sig(0, 40, n);
        repeat (15) @(negedge clk);
        k = int'($urandom_range(1, 3));
        for (int i = 0; i < k; i++) begin
            key = 1'b1; repeat (4) @(negedge clk);
            key = 1'b0; repeat (4) @(negedge clk);
        end
        wait_sig(0, 30, n);
        checks++; if (turn !== 1'b1 || n < 0) $display("FAIL turn_collapsed: got %b expected 1 (presses %0d)", turn, k); else passed++;
        wait_sig(0, 30, n);
        checks++; if (turn !== 1'b0 || n < 0) $display("FAIL turn_cleared: got %b expected 0", turn); else passed++;
        checks++; if (n !== T_INIT) $display("FAIL turn_spacing: got %0d expected %0d", n, T_INIT); else passed++;
        // press pulse lands exactly on the step-generating cycle
        repeat (13) @(negedge clk);
        key = 1'b1;
        wait_sig(0, 30, n);
        checks++; if (turn !== 1'b0 || n < 0) $display("FAIL coincident_not_merged: got %b expected 0", turn); else passed++;
        key = 1'b0;
        wait_sig(0, 30, n);
        checks++; if (turn !== 1'b1 || n < 0) $display("FAIL coincident_next_step: got %b expected 1", turn); else passed++;
        wait_sig(0, 30, n);
        checks++; if (turn !== 1'b0 || n < 0) $display("FAIL coincident_after: got %b expected 0", turn); else passed++;
    endtask

    task automatic test_speedup();
        int n, d;
        for (int i = 1; i <= 4; i++) begin
            wait_sig(0, 40, n);
            d = (i == 1) ? int'($urandom_range(16, 17)) : int'($urandom_range(1, 4));
            repeat (d) @(negedge clk);
            eaten = 1'b1;
            @(negedge clk);
            eaten = 1'b0;
            eaten_total++;
            checks++; if (int'(score) !== exp_score(eaten_total)) $display("FAIL speed_score%0d: got %0d expected %0d", i, score, exp_score(eaten_total)); else passed++;
            checks++; if (int'(period) !== exp_period(eaten_total)) $display("FAIL speed_period%0d: got %0d expected %0d", i, period, exp_period(eaten_total)); else passed++;
            if (i == 1) begin
                @(negedge clk);
                checks++; if (step !== 1'b1) $display("FAIL late_eat_step: got %b expected 1", step); else passed++;
            end else begin
                wait_sig(0, 40, n);
            end
            wait_sig(0, 40, n);
            checks++; if (n !== exp_period(eaten_total)) $display("FAIL speed_spacing%0d: got %0d expected %0d", i, n, exp_period(eaten_total)); else passed++;
        end
    endtask

    task automatic test_saturation();
        int gap;
        for (int i = 0; i < 260; i++) begin
            eaten = 1'b1;
            @(negedge clk);
            eaten = 1'b0;
            eaten_total++;
            if (i % 65 == 64) begin
                checks++; if (int'(score) !== exp_score(eaten_total)) $display("FAIL sat_score_mid: got %0d expected %0d", score, exp_score(eaten_total)); else passed++;
            end
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end
        checks++; if (score !== 8'd255) $display("FAIL sat_score: got %0d expected 255", score); else passed++;
        checks++; if (int'(period) !== T_MIN) $display("FAIL sat_period: got %0d expected %0d", period, T_MIN); else passed++;
    endtask

    task automatic test_collision();
        int n, g, sc0;
        wait_sig(0, 40, n);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        @(negedge clk);
        checks++; if (running !== 1'b1) $display("FAIL coll_in_step_cycle: got running %b expected 1", running); else passed++;
        g = int'($urandom_range(1, 3));
        repeat (g) @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        checks++; if (running !== 1'b1) $display("FAIL coll_mid_period: got running %b expected 1", running); else passed++;
        wait_sig(0, 40, n);
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        checks++; if (game_over !== 1'b1) $display("FAIL coll_game_over: got %b expected 1", game_over); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL coll_running: got %b expected 0", running); else passed++;
        sc0 = step_cnt;
        key = 1'b1; repeat (8) @(negedge clk);
        key = 1'b0; repeat (8) @(negedge clk);
        checks++; if (game_over !== 1'b1) $display("FAIL early_press_ignored: got game_over %b expected 1", game_over); else passed++;
        eaten = 1'b1; @(negedge clk); eaten = 1'b0;
        checks++; if (int'(score) !== exp_score(eaten_total)) $display("FAIL over_score_frozen: got %0d expected %0d", score, exp_score(eaten_total)); else passed++;
        checks++; if (int'(period) !== exp_period(eaten_total)) $display("FAIL over_period_frozen: got %0d expected %0d", period, exp_period(eaten_total)); else passed++;
        repeat (10) @(negedge clk);
        checks++; if (step_cnt - sc0 !== 0) $display("FAIL over_no_steps: got %0d expected 0", step_cnt - sc0); else passed++;
        key = 1'b1;
        wait_sig(2, 15, n);
        checks++; if (n < 6 || n > 8) $display("FAIL over_exit_latency: got %0d expected 6..8", n); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL idle_running: got %b expected 0", running); else passed++;
        checks++; if (int'(score) !== exp_score(eaten_total)) $display("FAIL idle_score_kept: got %0d expected %0d", score, exp_score(eaten_total)); else passed++;
        key = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (running !== 1'b0) $display("FAIL release_no_start: got running %b expected 0", running); else passed++;
        key = 1'b1;
        wait_sig(1, 20, n);
        key = 1'b0;
        eaten_total = 0;
        checks++; if (n < 0 || running !== 1'b1) $display("FAIL restart: got running %b expected 1", running); else passed++;
        checks++; if (score !== 8'd0) $display("FAIL restart_score: got %0d expected 0", score); else passed++;
        checks++; if (int'(period) !== T_INIT) $display("FAIL restart_period: got %0d expected %0d", period, T_INIT); else passed++;
    endtask

    task automatic test_reset_midrun();
        int n, c0;
        repeat (9) @(negedge clk);
        key = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (step !== 1'b0 || turn !== 1'b0 || clear !== 1'b0) $display("FAIL midrst_pulses: got %b%b%b expected 000", step, turn, clear); else passed++;
        checks++; if (running !== 1'b0 || game_over !== 1'b0) $display("FAIL midrst_state: got %b%b expected 00", running, game_over); else passed++;
        checks++; if (score !== 8'd0 || int'(period) !== T_INIT) $display("FAIL midrst_regs: got %0d/%0d expected 0/%0d", score, period, T_INIT); else passed++;
        c0 = clear_cnt;
        rst = 1'b0;
        wait_sig(1, 20, n);
        checks++; if (n < 6 || n > 8) $display("FAIL midrst_press_latency: got %0d expected 6..8", n); else passed++;
        repeat (5) @(negedge clk);
        key = 1'b0;
        wait_sig(0, 40, n);
        checks++; if (turn !== 1'b0 || n < 0) $display("FAIL midrst_release_no_press: got turn %b expected 0", turn); else passed++;
        checks++; if (clear_cnt - c0 !== 1) $display("FAIL midrst_one_press: got %0d expected 1", clear_cnt - c0); else passed++;
    endtask

    initial begin
        test_reset();
        test_bouncy_start();
        test_turns();
        test_speedup();
        test_saturation();
        test_collision();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
